// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin front end for one shared iterative Booth multiplier. Requesters
//   hand in an operand pair with valid/ready. The arbiter holds the operands on
//   the multiplier for LATENCY cycles with pip_en high, samples the product, and
//   returns it to the granted requester with valid/ready.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   req_valid       [NREQ]           per-requester request valid
//   req_ready       [NREQ]           one-hot accept, combinational, IDLE only
//   req_a / req_b   [NREQ*WIDTH]     packed operands, requester i at [i*W +: W]
//   resp_valid      [NREQ]           one-hot result valid
//   resp_ready      [NREQ]           per-requester result accept
//   resp_data       [WIDTH_MUL]      product for the flagged requester
//   mul_pip_en, mul_a, mul_b         drive the shared multiplier
//   mul_out         [WIDTH_MUL]      multiplier result
//   busy                             operation in flight (RUN or RESP)
//   grant_id                         current / most recent grant
//   done_cnt        [16]             completed operations, wraps
module booth_mul_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = 32,
    parameter int LATENCY   = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH_A-1:0]   req_a,
    input  logic [NREQ*WIDTH_B-1:0]   req_b,
    output logic [NREQ-1:0]           resp_valid,
    input  logic [NREQ-1:0]           resp_ready,
    output logic [WIDTH_MUL-1:0]      resp_data,
    output logic                      mul_pip_en,
    output logic [WIDTH_A-1:0]        mul_a,
    output logic [WIDTH_B-1:0]        mul_b,
    input  logic [WIDTH_MUL-1:0]      mul_out,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [15:0]               done_cnt
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t                          state;
    logic [GW-1:0]                   rr_ptr;
    logic [CW-1:0]                   cnt;

    // Per-requester views of the packed operand buses.
    logic [NREQ-1:0][WIDTH_A-1:0]    a_vec;
    logic [NREQ-1:0][WIDTH_B-1:0]    b_vec;
    assign a_vec = req_a;
    assign b_vec = req_b;

    // Round-robin search: first valid requester strictly after rr_ptr, wrapping.
    logic                            pick_found;
    logic [GW-1:0]                   pick_idx;
    logic [GW-1:0]                   scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = GW'((int'(rr_ptr) + k) % NREQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Accept is combinational; reset in the same cycle suppresses the handshake.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && pick_found && !rst)
            req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= GW'(NREQ - 1);
            cnt        <= '0;
            grant_id   <= '0;
            mul_pip_en <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
            done_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        mul_a      <= a_vec[pick_idx];
                        mul_b      <= b_vec[pick_idx];
                        mul_pip_en <= 1'b1;
                        grant_id   <= pick_idx;
                        rr_ptr     <= pick_idx;
                        cnt        <= CW'(LATENCY - 1);
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // cnt reaches 0 in the LATENCY-th cycle with operands held.
                    if (cnt == '0) begin
                        resp_data  <= mul_out;
                        mul_pip_en <= 1'b0;
                        mul_a      <= '0;
                        mul_b      <= '0;
                        resp_valid <= ONE_HOT0 << grant_id;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // Only the granted requester's ready is looked at.
                    if (resp_ready[grant_id]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        done_cnt   <= done_cnt + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int L    = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready = '0;
    logic [31:0] resp_data;
    logic        mul_pip_en;
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_out;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] done_cnt;

    booth_mul_arbiter #(.NREQ(4), .WIDTH_A(16), .WIDTH_B(16), .WIDTH_MUL(32), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .mul_pip_en(mul_pip_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_out(mul_out), .busy(busy), .grant_id(grant_id), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Multiplier stand-in: product is only correct in the L-th consecutive
    // pip_en cycle, garbage otherwise, so a wrong sampling point shows up.
    logic [7:0] pcnt = 8'd0;
    always @(posedge clk) pcnt <= mul_pip_en ? 8'(pcnt + 8'd1) : 8'd0;
    assign mul_out = (mul_pip_en && pcnt == 8'(L - 1)) ? smul(mul_a, mul_b) : 32'hDEAD_BEEF;

    typedef struct { int cyc; int id; logic [31:0] data; } ev_t;
    ev_t acc_q[$];
    ev_t rsp_q[$];

    int n_chk = 0, n_pass = 0, pip_cnt = 0, cyc = 0;
    logic [3:0] acc_mask = '0;
    bit hold_all = 0;

    // Transaction-level model: one op in flight, described by its accept cycle.
    bit          model_ok = 0, m_active = 0;
    int          m_acc = 0, m_gid = 0, m_rr = NREQ - 1;
    logic [15:0] m_a = '0, m_b = '0, m_done = '0;
    logic [31:0] m_prod = '0, m_rdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int pick(input int rr, input logic [3:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    task automatic monitor();
        logic [3:0] er;
        int g;
        bit run, rsp;
        g = pick(m_rr, req_valid);
        if (model_ok) begin
            er = '0;
            if (!m_active && !rst && g >= 0) er[g] = 1'b1;
            run = m_active && cyc <= m_acc + L;
            rsp = m_active && !run;
            chk("req_ready", req_ready, er);
            chk("resp_valid", resp_valid, rsp ? (4'b0001 << m_gid) : 4'b0000);
            chk("resp_data", resp_data, m_rdata);
            chk("mul_pip_en", mul_pip_en, run);
            chk("mul_a", mul_a, run ? m_a : 16'h0);
            chk("mul_b", mul_b, run ? m_b : 16'h0);
            chk("busy", busy, m_active);
            chk("grant_id", grant_id, m_gid);
            chk("done_cnt", done_cnt, m_done);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) acc_q.push_back('{cyc, i, 32'h0});
                if (resp_valid[i] && resp_ready[i]) rsp_q.push_back('{cyc, i, resp_data});
            end
            if (mul_pip_en) pip_cnt++;
        end
        acc_mask = req_ready;
        if (rst) begin
            m_active = 0; m_rr = NREQ - 1; m_gid = 0; m_done = '0; m_rdata = '0;
            model_ok = 1;
        end else if (!m_active) begin
            if (g >= 0) begin
                m_active = 1; m_acc = cyc; m_gid = g; m_rr = g;
                m_a = req_a[g*16 +: 16];
                m_b = req_b[g*16 +: 16];
                m_prod = smul(m_a, m_b);
            end
        end else if (cyc == m_acc + L) begin
            m_rdata = m_prod;
        end else if (cyc > m_acc + L && resp_ready[m_gid]) begin
            m_active = 0;
            m_done = m_done + 16'd1;
        end
        cyc++;
    endtask

    // One clock: compare at the falling edge, then retire accepted requests.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (!hold_all) req_valid = req_valid & ~acc_mask;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int bound);
        for (int k = 0; k < bound && acc_q.size() < n; k++) step();
        chk("wait_accept", acc_q.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int n, input int bound);
        for (int k = 0; k < bound && rsp_q.size() < n; k++) step();
        chk("wait_response", rsp_q.size() >= n, 1);
    endtask

    int a0, r0, p0;
    logic [15:0] ra, rb;

    initial begin
        // Reset state
        do_reset();
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_pip_en", mul_pip_en, 0);

        // Single request: 3*5 from requester 1
        resp_ready = 4'hF;
        a0 = acc_q.size(); r0 = rsp_q.size(); p0 = pip_cnt;
        set_req(1, 16'd3, 16'd5);
        wait_rsp(r0 + 1, 60);
        if (rsp_q.size() > r0 && acc_q.size() > a0) begin
            chk("t1_accepts", acc_q.size() - a0, 1);
            chk("t1_acc_id", acc_q[a0].id, 1);
            chk("t1_rsp_id", rsp_q[r0].id, 1);
            chk("t1_data", rsp_q[r0].data, 15);
            chk("t1_latency", rsp_q[r0].cyc - acc_q[a0].cyc, 12);
            chk("t1_pip_cycles", pip_cnt - p0, 11);
            chk("t1_done_cnt", done_cnt, 1);
        end

        // Simultaneous: req0 12*4 and req2 7*9
        do_reset();
        a0 = acc_q.size(); r0 = rsp_q.size();
        set_req(0, 16'd12, 16'd4);
        set_req(2, 16'd7, 16'd9);
        wait_rsp(r0 + 2, 100);
        if (rsp_q.size() >= r0 + 2 && acc_q.size() >= a0 + 2) begin
            chk("t2_first_id", acc_q[a0].id, 0);
            chk("t2_second_id", acc_q[a0+1].id, 2);
            chk("t2_data0", rsp_q[r0].data, 48);
            chk("t2_data2", rsp_q[r0+1].data, 63);
            chk("t2_idle_gap", acc_q[a0+1].cyc - rsp_q[r0].cyc, 1);
        end

        // Fairness: all valid, A=i+1, B=10
        do_reset();
        a0 = acc_q.size(); r0 = rsp_q.size();
        hold_all = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(i + 1), 16'd10);
        wait_acc(a0 + 5, 120);
        hold_all = 0;
        req_valid = '0;
        if (acc_q.size() >= a0 + 5 && rsp_q.size() >= r0 + 4) begin
            for (int k = 0; k < 5; k++) chk("t3_order", acc_q[a0+k].id, k % 4);
            for (int k = 0; k < 4; k++) chk("t3_data", rsp_q[r0+k].data, (k + 1) * 10);
            for (int k = 1; k < 5; k++) chk("t3_spacing", acc_q[a0+k].cyc - acc_q[a0+k-1].cyc, 13);
        end

        // Backpressure: 15*15 held for 5 cycles
        do_reset();
        a0 = acc_q.size(); r0 = rsp_q.size();
        resp_ready = 4'h0;
        set_req(0, 16'd15, 16'd15);
        for (int k = 0; k < 40 && resp_valid == 4'h0; k++) step();
        chk("t4_resp_rise", resp_valid, 4'b0001);
        set_req(1, 16'd2, 16'd2);
        repeat (5) step();
        chk("t4_no_accept", acc_q.size() - a0, 1);
        chk("t4_hold_valid", resp_valid, 4'b0001);
        chk("t4_hold_data", resp_data, 225);
        resp_ready = 4'hF;
        wait_acc(a0 + 2, 10);
        if (acc_q.size() >= a0 + 2 && rsp_q.size() > r0) begin
            chk("t4_data", rsp_q[r0].data, 225);
            chk("t4_next_id", acc_q[a0+1].id, 1);
            chk("t4_idle_gap", acc_q[a0+1].cyc - rsp_q[r0].cyc, 1);
        end
        wait_rsp(r0 + 2, 30);

        // Reset mid-operation in RUN cycle 4
        do_reset();
        a0 = acc_q.size(); r0 = rsp_q.size();
        set_req(1, 16'd5, 16'd6);
        wait_acc(a0 + 1, 10);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_pip_en", mul_pip_en, 0);
        chk("t5_resp_data", resp_data, 0);
        chk("t5_grant_id", grant_id, 0);
        chk("t5_mul_a", mul_a, 0);
        repeat (20) step();
        chk("t5_no_resp", rsp_q.size() - r0, 0);
        a0 = acc_q.size();
        set_req(3, 16'd100, 16'd100);
        set_req(0, 16'd1, 16'd1);
        wait_rsp(r0 + 2, 100);
        if (acc_q.size() >= a0 + 2 && rsp_q.size() >= r0 + 2) begin
            chk("t5_prio0", acc_q[a0].id, 0);
            chk("t5_then3", acc_q[a0+1].id, 3);
            chk("t5_data", rsp_q[r0+1].data, 10000);
        end

        // Withdrawn request from requester 2
        do_reset();
        a0 = acc_q.size(); r0 = rsp_q.size();
        set_req(0, 16'd9, 16'd9);
        wait_acc(a0 + 1, 10);
        step();
        set_req(2, 16'd4, 16'd4);
        repeat (3) step();
        req_valid[2] = 1'b0;
        wait_rsp(r0 + 1, 30);
        repeat (5) step();
        chk("t6_accepts", acc_q.size() - a0, 1);
        if (rsp_q.size() > r0) chk("t6_data", rsp_q[r0].data, 81);

        // Randomized traffic with backpressure, withdrawals and resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 300 == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom % 5 == 0) begin
                    case ($urandom % 5)
                        0: ra = 16'h8000;
                        1: ra = 16'hFFFF;
                        default: ra = 16'($urandom);
                    endcase
                    rb = ($urandom % 6 == 0) ? 16'h7FFF : 16'($urandom);
                    set_req(i, ra, rb);
                end else if (req_valid[i] && $urandom % 40 == 0) begin
                    req_valid[i] = 1'b0;
                end
                resp_ready[i] = ($urandom % 4 != 0);
            end
            step();
        end
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
- Round-robin scheduler that shares one iterative Multiplier_booth instance among NREQ requesters.
- Accepts one operand pair at a time with a valid/ready handshake and drives the multiplier's A/B/pip_en.
- Waits the multiplier's fixed latency, captures OUT, and returns the product to the granted requester with a valid/ready response.
- Sits between the systolic-array control/PE clusters and the shared multiplier.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH_A, 16, operand A width.
- WIDTH_B, 16, operand B width.
- WIDTH_MUL, 32, product width (WIDTH_A+WIDTH_B).
- LATENCY, 11, cycles the multiplier needs with operands held and pip_en high ((max(WIDTH_A,WIDTH_B)+1)/2 + 1 + STAGE).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept pulse.
- req_a  in  NREQ*WIDTH_A  packed operand A; requester i at [i*WIDTH_A +: WIDTH_A].
- req_b  in  NREQ*WIDTH_B  packed operand B; same packing.
- resp_valid  out  NREQ  one-hot result valid.
- resp_ready  in  NREQ  per-requester result accept.
- resp_data  out  WIDTH_MUL  product for the requester flagged in resp_valid.
- mul_pip_en  out  1  to multiplier pip_en.
- mul_a  out  WIDTH_A  to multiplier A.
- mul_b  out  WIDTH_B  to multiplier B.
- mul_out  in  WIDTH_MUL  from multiplier OUT.
- busy  out  1  high in RUN or RESP.
- grant_id  out  clog2(NREQ)  index of the current or most recent grant.
- done_cnt  out  16  completed-operation counter; wraps at 0xFFFF→0.

Behaviour:
- Reset values: all outputs 0; rr_ptr = NREQ-1, so requester 0 has first priority; state IDLE; cycle counter 0.
- The reset is synchronous and overrides everything, including mid-RUN or mid-RESP. The operation in flight is dropped with no response. Reset asserted in the same cycle as a handshake wins.
- States: IDLE, RUN, RESP.
- IDLE:
  - mul_pip_en=0; mul_a=0; mul_b=0.
  - If any req_valid is high, pick g = first set bit searching from rr_ptr+1 upward, modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle; other bits stay 0.
  - On the edge: latch req_a[g] and req_b[g], grant_id←g, rr_ptr←g, counter←LATENCY-1, go to RUN.
  - req_ready is never asserted outside IDLE.
- RUN:
  - mul_pip_en=1; mul_a/mul_b driven from the latched operands, stable for exactly LATENCY cycles.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0: on the edge, resp_data←mul_out, go to RESP.
- RESP:
  - mul_pip_en=0; resp_valid[grant_id]=1; resp_data held stable.
  - When resp_ready[grant_id]=1: on the edge, clear resp_valid, done_cnt+=1, go to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
  - No bound on backpressure duration.
- Timing:
  - Accept happens in cycle t. RUN covers cycles t+1..t+LATENCY. resp_valid is first high in cycle t+LATENCY+1.
  - Minimum issue-to-issue spacing is LATENCY+2 cycles: one IDLE bubble after each response handshake.
- Arbitration:
  - The pointer advances only on a grant.
  - A requester that drops req_valid before being granted is not serviced and is not penalized.
  - With all requesters continuously valid, the grant order is 0,1,2,…,NREQ-1,0.
  - Requests are not queued; req_valid must stay high until req_ready.
- Arithmetic: the arbiter never modifies data; the product width and signedness are those of the multiplier.

Test Plan:
- Single request: requester 1 sends A=3, B=5, resp_ready tied high → req_ready[1] pulses one cycle; mul_pip_en high for exactly 11 cycles; resp_valid=4'b0010 with resp_data=15 in cycle accept+12; done_cnt=1.
- Simultaneous requests: req_valid=4'b0101 (req0 12×4, req2 7×9) → req0 granted first with result 48; req2 granted in the IDLE cycle after req0's response, result 63; grant_id sequence 0,2.
- Fairness: all four requesters valid continuously with A=i+1, B=10 → grant order 0,1,2,3,0; results 10,20,30,40; each issue spaced 13 cycles apart.
- Backpressure: 15×15 with resp_ready held low for 5 cycles after resp_valid rises → resp_valid and resp_data=225 stay stable; no new req_ready pulses during the hold; IDLE is reached one cycle after resp_ready rises.
- Reset mid-operation: rst asserted for 1 cycle during RUN cycle 4 → next cycle all outputs are 0 and the state is IDLE; no resp_valid ever appears for the aborted op. A subsequent req3 100×100 returns 10000, and requester 0 again has top priority.
- Withdrawn request: req_valid[2] pulses during another requester's RUN and drops before IDLE → it is never granted; req_ready[2] stays 0.
